// File: rtl/dma_read_arbiter_if.sv
// Bundles the channel-side and memory-side read buses of the DMA read arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dma_read_arbiter_if #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_OUTST  = 8
) ();
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [NUM_CH-1:0]            ch_enable;
   logic [NUM_CH*ADDR_WIDTH-1:0] ch_req_addr;
   logic [NUM_CH-1:0]            ch_req_valid;
   logic [NUM_CH-1:0]            ch_req_ready;
   logic [DATA_WIDTH-1:0]        ch_rsp_data;
   logic [NUM_CH-1:0]            ch_rsp_valid;
   logic [ADDR_WIDTH-1:0]        mem_req_addr;
   logic                         mem_req_valid;
   logic                         mem_req_ready;
   logic [DATA_WIDTH-1:0]        mem_rsp_data;
   logic                         mem_rsp_valid;
   logic                         rsp_error_clr;
   logic                         rsp_error;
   logic [CNT_W-1:0]             outstanding;

   modport slave (
      input  ch_enable, ch_req_addr, ch_req_valid, mem_req_ready,
             mem_rsp_data, mem_rsp_valid, rsp_error_clr,
      output ch_req_ready, ch_rsp_data, ch_rsp_valid, mem_req_addr,
             mem_req_valid, rsp_error, outstanding
   );

   modport master (
      output ch_enable, ch_req_addr, ch_req_valid, mem_req_ready,
             mem_rsp_data, mem_rsp_valid, rsp_error_clr,
      input  ch_req_ready, ch_rsp_data, ch_rsp_valid, mem_req_addr,
             mem_req_valid, rsp_error, outstanding
   );
endinterface

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter funnelling NUM_CH DMA read channels onto one memory port,
// routing in-order read data back to the requester through a tag FIFO.
module dma_read_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_OUTST  = 8
) (
   input logic              clk,
   input logic              rst_n,
   dma_read_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
   logic [NUM_CH-1:0]     eligible;
   logic                  found;
   logic [IDX_W-1:0]      pick;
   logic [IDX_W-1:0]      cand;
   logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];

   logic [IDX_W-1:0]      tag_mem [MAX_OUTST];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  push, pop, not_full;
   logic                  rsp_error_q;
   logic                  mem_req_valid;
   logic [NUM_CH-1:0]     ch_req_ready;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr
      assign ch_addr[gi] = bus.ch_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
   end

   assign eligible = bus.ch_req_valid & bus.ch_enable;
   assign not_full = (count_q < MAX_CNT);

   // Rotating priority: the channel right after the last winner is looked at first.
   always_comb begin
      found = 1'b0;
      pick  = last_grant_q;
      cand  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = IDX_W'((int'(last_grant_q) + k) % NUM_CH);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      mem_req_valid = 1'b0;
      ch_req_ready  = '0;
      push          = 1'b0;
      case (state_q)
         IDLE: begin
            if (found && not_full) begin
               owner_d = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            mem_req_valid = 1'b1;
            if (bus.mem_req_ready) begin
               ch_req_ready = NUM_CH'(1) << owner_q;
               push         = 1'b1;
               last_grant_d = owner_q;
               state_d      = IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_grant_q <= IDX_W'(NUM_CH - 1);
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // A response with nothing in flight is dropped and flagged instead of popping.
   assign pop = bus.mem_rsp_valid && (count_q != '0);

   // NOTE: the tag storage has no reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= owner_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (bus.mem_rsp_valid && (count_q == '0)) rsp_error_q <= 1'b1;
         else if (bus.rsp_error_clr)               rsp_error_q <= 1'b0;
      end
   end

   assign bus.mem_req_valid = mem_req_valid;
   assign bus.mem_req_addr  = ch_addr[owner_q];
   assign bus.ch_req_ready  = ch_req_ready;
   assign bus.ch_rsp_valid  = pop ? (NUM_CH'(1) << tag_mem[rd_ptr_q]) : '0;
   assign bus.ch_rsp_data   = bus.mem_rsp_data;
   assign bus.rsp_error     = rsp_error_q;
   assign bus.outstanding   = count_q;
endmodule

// File: doc/dma_read_arbiter.md
DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channel requesters.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, read address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, read data width.
REQ-004 SHALL have parameter MAX_OUTST, default 8, maximum outstanding reads; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port ch_enable, input, NUM_CH bits: per-channel arbitration enable mask.
REQ-008 SHALL have port ch_req_addr, input, NUM_CH*ADDR_WIDTH bits: channel i address at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port ch_req_valid, input, NUM_CH bits: channel read request.
REQ-010 SHALL have port ch_req_ready, output, NUM_CH bits: request accepted.
REQ-011 SHALL have port ch_rsp_data, output, DATA_WIDTH bits: read data, broadcast to all channels.
REQ-012 SHALL have port ch_rsp_valid, output, NUM_CH bits: one-hot response strobe.
REQ-013 SHALL have port mem_req_addr, output, ADDR_WIDTH bits: shared read address.
REQ-014 SHALL have port mem_req_valid, output, 1 bit: shared request valid.
REQ-015 SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-016 SHALL have port mem_rsp_data, input, DATA_WIDTH bits: returned data, in request order.
REQ-017 SHALL have port mem_rsp_valid, input, 1 bit: returned data valid.
REQ-018 SHALL have port rsp_error_clr, input, 1 bit: clears rsp_error.
REQ-019 SHALL have port rsp_error, output, 1 bit: sticky flag for a response received with nothing outstanding.
REQ-020 SHALL have port outstanding, output, $clog2(MAX_OUTST)+1 bits: reads in flight.

Function
REQ-021 SHALL implement FSM IDLE/GRANT with registered owner index and registered last_grant index.
REQ-022 IDLE: when any bit of (ch_req_valid & ch_enable) is set and outstanding < MAX_OUTST, SHALL select the first such channel searching from last_grant+1 upward, wrapping modulo NUM_CH; owner takes that index; next state is GRANT. This gives one cycle of arbitration latency.
REQ-023 IDLE: mem_req_valid=0 and ch_req_ready=0.
REQ-024 GRANT: mem_req_valid=1 and mem_req_addr=owner slice of ch_req_addr; ch_req_ready[owner]=mem_req_ready, all other ready bits 0.
REQ-025 GRANT with mem_req_ready=1: SHALL push owner into the in-order tag FIFO (depth MAX_OUTST), set last_grant=owner, and return to IDLE. Peak rate is one request per 2 cycles.
REQ-026 GRANT with mem_req_ready=0: SHALL hold state; mem_req_addr and owner stay stable.
REQ-027 A requester holds ch_req_valid and its address until ready; clearing ch_enable[owner] during GRANT SHALL NOT abort the grant.
REQ-028 mem_rsp_valid=1 with the FIFO non-empty: ch_rsp_valid = one-hot of the FIFO head in the same cycle (combinational); ch_rsp_data = mem_rsp_data; the head is popped.
REQ-029 mem_rsp_valid=1 with the FIFO empty: SHALL drop the response, keep ch_rsp_valid=0, and set rsp_error on the next edge.
REQ-030 Push and pop in the same cycle: outstanding unchanged and FIFO order preserved. Full cannot overflow because GRANT is entered only when not full.
REQ-031 rsp_error_clr SHALL clear rsp_error; a simultaneous set takes priority.
REQ-032 outstanding SHALL equal pushes minus pops, within range 0..MAX_OUTST.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, owner=0, last_grant=NUM_CH-1 (so channel 0 wins first), FIFO empty, outstanding=0, rsp_error=0, and all valid/ready outputs 0.
REQ-034 Reset mid-GRANT or with reads outstanding SHALL discard all state; later responses count as unexpected (REQ-029).

Verification
REQ-035 Single request: ch_req_valid=0001, addr 0x1000, ready=1 -> mem_req_valid=1 addr 0x1000 in cycle 2; outstanding=1; a mem response yields ch_rsp_valid=0001 with matching data; outstanding=0.
REQ-036 Round-robin: all 4 channels valid continuously, ready=1 -> grant order 0,1,2,3,0, one grant per 2 cycles.
REQ-037 Backpressure: mem_req_ready=0 for 5 cycles in GRANT -> mem_req_addr stable, ch_req_ready all 0, no push; accepted on the 6th cycle.
REQ-038 Full: 8 accepted reads with no responses -> outstanding=8 and no GRANT entry; one response -> outstanding=7 and arbitration resumes.
REQ-039 Enable mask: ch_enable=1010 with all valid -> only channels 1 and 3 granted, alternating.
REQ-040 Error: mem_rsp_valid with outstanding=0 -> rsp_error=1 and no ch_rsp_valid; rsp_error_clr -> 0. Reset asserted mid-GRANT -> all outputs 0 immediately.
